stream_unpacker: RTL and testbench
==================================

# stream_unpacker

Parametrised width-down converter for the vision stream path. It accepts one packed word per handshake and emits its fixed-width lanes one per handshake, in a configurable order. The output is registered, throughput is sustained at one lane per cycle, and each word's final lane is tagged. It sits between the byte-wide UART/host receive path and the narrow pixel/weight consumers, and replaces fixed 8-to-2 unpacking.

## Interface
Parameters:
- packed_width_p, 8, width of input word; must be an integer multiple of unpacked_width_p
- unpacked_width_p, 2, width of one output lane
- msb_first_p, 0, 0: lane 0 = bits [unpacked_width_p-1:0] first; 1: most-significant lane first
- Derived, not overridable: num_lanes_lp = packed_width_p/unpacked_width_p (≥2); lane_cnt_w_lp = $clog2(num_lanes_lp+1)

Ports:
- clk_i  input  1  single clock, all state on rising edge
- reset_i  input  1  synchronous, active-high reset
- packed_i  input  packed_width_p  packed word
- lanes_i  input  lane_cnt_w_lp  lanes of packed_i to emit; meaningful only with UNPACKER_PARTIAL_EN
- valid_i  input  1  packed_i/lanes_i valid
- ready_o  output  1  block accepts a word this cycle
- unpacked_o  output  unpacked_width_p  current lane
- last_o  output  1  unpacked_o is the final lane of its word
- valid_o  output  1  unpacked_o/last_o valid
- ready_i  input  1  downstream accepts the lane

## Operation
- Accept: in_fire = valid_i & ready_o. It captures packed_i and the effective lane count into the hold register, clears the lane index, and sets busy.
- Lane select: the lane index counts 0..n-1. Emitted lane = index, or (num_lanes_lp-1-index) when msb_first_p=1.
- Output stage: a one-entry register (unpacked_o, last_o, valid_o).
  - It loads when busy & (~valid_o | ready_i) (lane_fire).
  - Each lane_fire advances the index.
  - The lane_fire on index n-1 sets last_o with that lane and clears busy, unless in_fire occurs in the same cycle.
- ready_o = ~reset_i & (~busy | final lane_fire this cycle). When a word completes and a new word arrives in the same cycle, the new word loads with no bubble.
- Out fire: valid_o & ready_i with no new lane loading clears valid_o. unpacked_o holds its last value (datapath-gated).
- Output values are stable while valid_o & ~ready_i (no change until taken).
- Reset values:
  - busy=0, index=0, hold=0.
  - valid_o=0, unpacked_o=0, last_o=0.
  - ready_o=0 during reset, 1 in the first cycle after reset.
- Reset mid-word discards the remaining lanes and any pending output lane.

## Timing
- Latency: a word accepted at edge N presents lane 0 (valid_o=1) after edge N+1.
- Throughput: one lane per cycle with ready_i held high, including across word boundaries (n lanes per n cycles, no idle cycle).
- Backpressure: ready_i low freezes the output register and index. ready_o stays low while busy and the final lane has not fired.
- Wrap: the index returns to 0 on every in_fire. It never counts past n-1.

## Configuration
- UNPACKER_PARTIAL_EN defined: n = lanes_i sampled at in_fire. lanes_i=0 or > num_lanes_lp is treated as num_lanes_lp. last_o marks lane n-1; unemitted lanes are dropped.
- UNPACKER_PARTIAL_EN undefined: lanes_i is ignored and n = num_lanes_lp always, with no lane-count register.

## Test plan
- Defaults, ready_i=1, packed_i=0xE4: unpacked_o = 0,1,2,3 on consecutive cycles starting 2 cycles after valid_i; last_o only with 3.
- msb_first_p=1, packed_i=0xE4: unpacked_o = 3,2,1,0; last_o with final 0.
- packed_width_p=16, unpacked_width_p=4, back-to-back 0x4321 then 0x8765 with ready_i=1: 1,2,3,4,5,6,7,8 with no gap; ready_o high exactly on the lane-4 fire cycle; last_o on 4 and 8.
- Defaults, 0xE4 with ready_i toggling 1,0,0,1,…: each lane holds while ready_i=0; sequence 0,1,2,3 intact; ready_o low until lane 3 fires.
- UNPACKER_PARTIAL_EN, defaults, 0xE4 with lanes_i=2, then 0x1B with lanes_i=0: outputs 0,1(last), then 3,2,1,0(last).
- reset_i pulsed for 1 cycle after lane 1 of 0xE4: valid_o=0 next cycle, no lanes 2/3 emitted; next word 0x1B yields 3,2,1,0.

Source files
------------

// File: rtl/stream_unpacker.sv
// Width-down converter: one packed word in, its lanes out one per handshake, final lane tagged.
// Optional feature macro UNPACKER_PARTIAL_EN: per-word lane count taken from lanes_i.
module stream_unpacker #(
  parameter int packed_width_p   = 8,
  parameter int unpacked_width_p = 2,
  parameter int msb_first_p      = 0,
  localparam int num_lanes_lp    = packed_width_p / unpacked_width_p,
  localparam int lane_cnt_w_lp   = $clog2(num_lanes_lp + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [packed_width_p-1:0]   packed_i,
  input  logic [lane_cnt_w_lp-1:0]    lanes_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [unpacked_width_p-1:0] unpacked_o,
  output logic                        last_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                      state_q, state_d;
  logic [packed_width_p-1:0]   hold_q, hold_d;
  logic [lane_cnt_w_lp-1:0]    idx_q, idx_d;
  logic [unpacked_width_p-1:0] unpacked_q, unpacked_d;
  logic                        last_q, last_d;
  logic                        valid_q, valid_d;

  logic [lane_cnt_w_lp-1:0]    n_lanes;
  logic [lane_cnt_w_lp-1:0]    lane_sel;
  logic [unpacked_width_p-1:0] lane_data;
  logic                        final_lane;
  logic                        lane_fire;
  logic                        final_fire;
  logic                        in_fire;
  logic                        ready;

`ifdef UNPACKER_PARTIAL_EN
  logic [lane_cnt_w_lp-1:0] cnt_q;
  logic [lane_cnt_w_lp-1:0] lanes_eff;

  always_comb begin
    if (lanes_i == '0 || lanes_i > lane_cnt_w_lp'(num_lanes_lp)) begin
      lanes_eff = lane_cnt_w_lp'(num_lanes_lp);
    end else begin
      lanes_eff = lanes_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (in_fire) begin
      cnt_q <= lanes_eff;
    end
  end

  assign n_lanes = cnt_q;
`else
  logic unused_lanes;
  assign unused_lanes = ^lanes_i;
  assign n_lanes      = lane_cnt_w_lp'(num_lanes_lp);
`endif

  assign final_lane = (idx_q == n_lanes - lane_cnt_w_lp'(1));

  always_comb begin
    if (msb_first_p != 0) begin
      lane_sel = lane_cnt_w_lp'(num_lanes_lp - 1) - idx_q;
    end else begin
      lane_sel = idx_q;
    end
  end

  always_comb begin
    lane_data = '0;
    for (int unsigned i = 0; i < num_lanes_lp; i++) begin
      if (lane_sel == lane_cnt_w_lp'(i)) begin
        lane_data = hold_q[i*unpacked_width_p +: unpacked_width_p];
      end
    end
  end

  // State register (also holds the datapath and output stage).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      unpacked_q <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      unpacked_q <= unpacked_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state: a finishing word and a newly accepted word can share a cycle;
  // the new word's capture overrides the finishing lane's return to IDLE.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    unpacked_d = unpacked_q;
    last_d     = last_q;
    valid_d    = valid_q;
    if (lane_fire) begin
      unpacked_d = lane_data;
      last_d     = final_lane;
      valid_d    = 1'b1;
      if (final_lane) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + lane_cnt_w_lp'(1);
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (in_fire) begin
      hold_d  = packed_i;
      idx_d   = '0;
      state_d = BUSY;
    end
  end

  // Handshake / outputs.
  always_comb begin
    lane_fire  = (state_q == BUSY) && (!valid_q || ready_i);
    final_fire = lane_fire && final_lane;
    ready      = !reset_i && ((state_q == IDLE) || final_fire);
    in_fire    = valid_i && ready;
  end

  assign ready_o    = ready;
  assign unpacked_o = unpacked_q;
  assign last_o     = last_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_stream_unpacker.sv
// Bench for stream_unpacker: three configurations (8/2 lsb, 8/2 msb, 16/4 lsb) on a shared handshake,
// cycle tables for directed cases and a queue-based reference for random traffic.
module tb_stream_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin;
  logic        rin;
  logic [2:0]  lanes;
  logic [7:0]  p8;
  logic [15:0] p16;

  logic       rdy0, rdy1, rdy2;
  logic       vld0, vld1, vld2;
  logic       lst0, lst1, lst2;
  logic [1:0] d0, d1;
  logic [3:0] d2;

  always #5 clk = ~clk;

  stream_unpacker #(.packed_width_p(8), .unpacked_width_p(2), .msb_first_p(0)) dut0 (
    .clk_i(clk), .reset_i(rst), .packed_i(p8), .lanes_i(lanes), .valid_i(vin), .ready_o(rdy0),
    .unpacked_o(d0), .last_o(lst0), .valid_o(vld0), .ready_i(rin));

  stream_unpacker #(.packed_width_p(8), .unpacked_width_p(2), .msb_first_p(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .packed_i(p8), .lanes_i(lanes), .valid_i(vin), .ready_o(rdy1),
    .unpacked_o(d1), .last_o(lst1), .valid_o(vld1), .ready_i(rin));

  stream_unpacker #(.packed_width_p(16), .unpacked_width_p(4), .msb_first_p(0)) dut2 (
    .clk_i(clk), .reset_i(rst), .packed_i(p16), .lanes_i(lanes), .valid_i(vin), .ready_o(rdy2),
    .unpacked_o(d2), .last_o(lst2), .valid_o(vld2), .ready_i(rin));

  typedef struct {
    logic       rs;
    logic       v;
    logic       r;
    logic [2:0] ln;
    logic [7:0] a;
    logic [15:0] b;
    logic       erdy;
    logic       evld;
    logic       elast;
    logic [1:0] e0;
    logic [1:0] e1;
    logic [3:0] e2;
  } vec_t;

  typedef struct {
    logic [3:0] d;
    logic       l;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[3][$];

  int total = 0;
  int bad   = 0;

  logic       rdy_s[3];
  logic       vld_s[3];
  logic       lst_s[3];
  logic [3:0] dat_s[3];
  logic       pstall[3];
  logic       plast[3];
  logic [3:0] pdat[3];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(logic rs, logic v, logic r, logic [2:0] ln, logic [7:0] a,
                              logic [15:0] b, logic erdy, logic evld, logic elast,
                              logic [1:0] e0, logic [1:0] e1, logic [3:0] e2);
    vec_t t;
    t = '{rs, v, r, ln, a, b, erdy, evld, elast, e0, e1, e2};
    tbl.push_back(t);
  endfunction

  task automatic sample();
    rdy_s[0] = rdy0; vld_s[0] = vld0; lst_s[0] = lst0; dat_s[0] = {2'b00, d0};
    rdy_s[1] = rdy1; vld_s[1] = vld1; lst_s[1] = lst1; dat_s[1] = {2'b00, d1};
    rdy_s[2] = rdy2; vld_s[2] = vld2; lst_s[2] = lst2; dat_s[2] = d2;
  endtask

  task automatic run_table(string tag);
    logic [3:0] ed;
    foreach (tbl[i]) begin
      rst = tbl[i].rs; vin = tbl[i].v; rin = tbl[i].r; lanes = tbl[i].ln;
      p8 = tbl[i].a; p16 = tbl[i].b;
      @(negedge clk);
      sample();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("%s[%0d].ready_o.%0d", tag, i, k), 32'(rdy_s[k]), 32'(tbl[i].erdy));
        chk($sformatf("%s[%0d].valid_o.%0d", tag, i, k), 32'(vld_s[k]), 32'(tbl[i].evld));
        if (tbl[i].evld) begin
          ed = (k == 0) ? {2'b00, tbl[i].e0} : (k == 1) ? {2'b00, tbl[i].e1} : tbl[i].e2;
          chk($sformatf("%s[%0d].unpacked_o.%0d", tag, i, k), 32'(dat_s[k]), 32'(ed));
          chk($sformatf("%s[%0d].last_o.%0d", tag, i, k), 32'(lst_s[k]), 32'(tbl[i].elast));
        end
      end
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  // Reference: a word accepted by config k becomes an ordered list of expected lanes.
  task automatic push_word(int k);
    int n;
    int w;
    int pos;
    logic [15:0] word;
    exp_t e;
    w    = (k == 2) ? 4 : 2;
    word = (k == 2) ? p16 : {8'h00, p8};
`ifdef UNPACKER_PARTIAL_EN
    n = (lanes == 3'd0 || lanes > 3'd4) ? 4 : int'(lanes);
`else
    n = 4;
`endif
    for (int j = 0; j < n; j++) begin
      pos = (k == 1) ? (3 - j) : j;
      e.d = 4'((32'(word) >> (pos * w)) & ((32'd1 << w) - 1));
      e.l = (j == n - 1);
      sbq[k].push_back(e);
    end
  endtask

  task automatic sb_step();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (pstall[k]) begin
        chk($sformatf("stall.valid_o.%0d", k), 32'(vld_s[k]), 32'd1);
        chk($sformatf("stall.unpacked_o.%0d", k), 32'(dat_s[k]), 32'(pdat[k]));
        chk($sformatf("stall.last_o.%0d", k), 32'(lst_s[k]), 32'(plast[k]));
      end
      if (vld_s[k] && rin) begin
        if (sbq[k].size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb.extra_lane.%0d: got lane %0h expected none", k, dat_s[k]);
        end else begin
          e = sbq[k].pop_front();
          chk($sformatf("sb.unpacked_o.%0d", k), 32'(dat_s[k]), 32'(e.d));
          chk($sformatf("sb.last_o.%0d", k), 32'(lst_s[k]), 32'(e.l));
        end
      end
      if (vin && rdy_s[k]) push_word(k);
      pstall[k] = vld_s[k] && !rin;
      pdat[k]   = dat_s[k];
      plast[k]  = lst_s[k];
    end
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; rin = 1'b1; lanes = '0; p8 = '0; p16 = '0;
    for (int k = 0; k < 3; k++) begin
      pstall[k] = 1'b0; pdat[k] = '0; plast[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset.ready_o.%0d", k), 32'(rdy_s[k]), 32'd0);
      chk($sformatf("reset.valid_o.%0d", k), 32'(vld_s[k]), 32'd0);
      chk($sformatf("reset.unpacked_o.%0d", k), 32'(dat_s[k]), 32'd0);
      chk($sformatf("reset.last_o.%0d", k), 32'(lst_s[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    sample();
    for (int k = 0; k < 3; k++)
      chk($sformatf("post_reset.ready_o.%0d", k), 32'(rdy_s[k]), 32'd1);
    @(posedge clk); #1;

    // Back-to-back words, ready_i high: no bubble between words
    //   rs v  r  ln  p8     p16       rdy vld lst e0 e1 e2
    add(0, 1, 1, 0, 8'hE4, 16'h4321, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'h1B, 16'h8765, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'h1B, 16'h8765, 0, 1, 0, 0, 3, 1);
    add(0, 1, 1, 0, 8'h1B, 16'h8765, 0, 1, 0, 1, 2, 2);
    add(0, 1, 1, 0, 8'h1B, 16'h8765, 1, 1, 0, 2, 1, 3);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 1, 3, 0, 4);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 3, 0, 5);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 2, 1, 6);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 1, 0, 1, 2, 7);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 1, 1, 0, 3, 8);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0);
    run_table("b2b");

    // Backpressure: ready_i = 1,0,0,1,...
    add(0, 1, 1, 0, 8'hE4, 16'h4321, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 0, 3, 1);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 0, 3, 1);
    add(0, 0, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 1, 2, 2);
    add(0, 0, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 1, 2, 2);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 1, 2, 2);
    add(0, 0, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 2, 1, 3);
    add(0, 0, 0, 0, 8'h00, 16'h0000, 0, 1, 0, 2, 1, 3);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 1, 0, 2, 1, 3);
    add(0, 0, 0, 0, 8'h00, 16'h0000, 1, 1, 1, 3, 0, 4);
    add(0, 0, 0, 0, 8'h00, 16'h0000, 1, 1, 1, 3, 0, 4);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 1, 1, 3, 0, 4);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0);
    run_table("bp");

    // Reset after lane 1 discards lanes 2/3; following word is clean
    add(0, 1, 1, 0, 8'hE4, 16'h4321, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 0, 3, 1);
    add(1, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 1, 2, 2);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'h1B, 16'h8765, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 3, 0, 5);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 2, 1, 6);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 1, 0, 1, 2, 7);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 1, 1, 0, 3, 8);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0);
    run_table("rst");

`ifdef UNPACKER_PARTIAL_EN
    // Partial words: 2 lanes, then lanes_i=0 meaning all lanes
    add(0, 1, 1, 2, 8'hE4, 16'h4321, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'h1B, 16'h8765, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 8'h1B, 16'h8765, 1, 1, 0, 0, 3, 1);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 1, 1, 2, 2);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 3, 0, 5);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 0, 2, 1, 6);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 1, 0, 1, 2, 7);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 1, 1, 0, 3, 8);
    add(0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0);
    run_table("partial");
`endif

    // Random traffic against the lane-list reference, then a drain phase
    for (int c = 0; c < 720; c++) begin
      rst   = 1'b0;
      vin   = (c < 600) ? (($urandom % 4) != 0) : 1'b0;
      rin   = (c < 600) ? (($urandom % 4) != 0) : 1'b1;
      lanes = 3'($urandom_range(0, 7));
      p8    = 8'($urandom);
      p16   = 16'($urandom);
      @(negedge clk);
      sample();
      sb_step();
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("sb.drained.%0d", k), 32'(sbq[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
